// File: rtl/cache_set_assoc_engine.sv
// rtl/cache_set_assoc_engine.sv - N-way set-associative cache tracking engine with tree-PLRU and MESI
module cache_set_assoc_engine #(
  parameter  int ADDR_W     = 32,
  parameter  int SETS       = 64,
  parameter  int WAYS       = 8,
  parameter  int LINE_BYTES = 64,
  parameter  int CNT_W      = 16,
  localparam int OFF_W      = $clog2(LINE_BYTES),
  localparam int IDX_W      = $clog2(SETS),
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W,
  localparam int WAY_W      = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              snoop_shared,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic [1:0]        resp_mesi,
  output logic              resp_evict,
  output logic              resp_evict_dirty,
  output logic [TAG_W-1:0]  resp_evict_tag,
  output logic              resp_flush,
  output logic [CNT_W-1:0]  hit_cntr,
  output logic [CNT_W-1:0]  miss_cntr,
  output logic [CNT_W-1:0]  read_cntr,
  output logic [CNT_W-1:0]  write_cntr
);

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  localparam logic [3:0] CMD_RD_D  = 4'd0;
  localparam logic [3:0] CMD_WR_D  = 4'd1;
  localparam logic [3:0] CMD_RD_I  = 4'd2;
  localparam logic [3:0] CMD_SN_IV = 4'd3;
  localparam logic [3:0] CMD_SN_RD = 4'd4;
  localparam logic [3:0] CMD_SN_WR = 4'd5;
  localparam logic [3:0] CMD_SN_RW = 4'd6;
  localparam logic [3:0] CMD_CLEAR = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_CLEAR} state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [1:0]        mesi_q [SETS][WAYS];
  logic [WAYS-2:0]   plru_q [SETS];

  logic [3:0]              cmd_q;
  logic [ADDR_W-OFF_W-1:0] line_q;
  logic                    hit_q;
  logic [WAY_W-1:0]        way_q;
  logic [1:0]              prior_q;
  logic [TAG_W-1:0]        vtag_q;
  logic [IDX_W-1:0]        clr_idx_q;

  logic              resp_valid_q, resp_hit_q, resp_evict_q, resp_dirty_q, resp_flush_q;
  logic [WAY_W-1:0]  resp_way_q;
  logic [1:0]        resp_mesi_q;
  logic [TAG_W-1:0]  resp_etag_q;
  logic [CNT_W-1:0]  hit_cntr_q, miss_cntr_q, read_cntr_q, write_cntr_q;

  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic              lk_hit, lk_free;
  logic [WAY_W-1:0]  lk_hit_way, lk_free_way, lk_way;

  // Byte-offset bits only select within a line and play no part in tracking.
  logic unused_off;
  assign unused_off = ^req_addr[OFF_W-1:0];

  assign cur_idx = line_q[IDX_W-1:0];
  assign cur_tag = line_q[TAG_W+IDX_W-1:IDX_W];

  // Walk the tree from the root following the bits: 0 goes left, 1 goes right.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_W-1:0] v;
    int node;
    v    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      v[WAY_W-1-l] = bits[node];
      node = 2 * node + 1 + int'(bits[node]);
    end
    return v;
  endfunction

  // Point every node on the path to way w at the opposite subtree.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits, input logic [WAY_W-1:0] w);
    logic [WAYS-2:0] r;
    int node;
    r    = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      r[node] = ~w[WAY_W-1-l];
      node = 2 * node + 1 + int'(w[WAY_W-1-l]);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Parallel tag compare plus lowest-index invalid way; descending loop leaves the lowest match.
  always_comb begin
    lk_hit      = 1'b0;
    lk_hit_way  = '0;
    lk_free     = 1'b0;
    lk_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mesi_q[cur_idx][w] != MESI_I && tag_q[cur_idx][w] == cur_tag) begin
        lk_hit     = 1'b1;
        lk_hit_way = WAY_W'(w);
      end
      if (mesi_q[cur_idx][w] == MESI_I) begin
        lk_free     = 1'b1;
        lk_free_way = WAY_W'(w);
      end
    end
    if (lk_hit)       lk_way = lk_hit_way;
    else if (lk_free) lk_way = lk_free_way;
    else              lk_way = plru_victim(plru_q[cur_idx]);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and handshake.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_cmd == CMD_CLEAR) ? S_CLEAR : S_LOOKUP;
      end
      S_LOOKUP: state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      S_CLEAR:  if (clr_idx_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: capture command, register lookup, commit arrays/counters and responses.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          mesi_q[s][w] <= MESI_I;
        end
      end
      cmd_q        <= '0;
      line_q       <= '0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      prior_q      <= MESI_I;
      vtag_q       <= '0;
      clr_idx_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_mesi_q  <= MESI_I;
      resp_evict_q <= 1'b0;
      resp_dirty_q <= 1'b0;
      resp_etag_q  <= '0;
      resp_flush_q <= 1'b0;
      hit_cntr_q   <= '0;
      miss_cntr_q  <= '0;
      read_cntr_q  <= '0;
      write_cntr_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            cmd_q     <= req_cmd;
            line_q    <= req_addr[ADDR_W-1:OFF_W];
            clr_idx_q <= '0;
          end
        end
        S_LOOKUP: begin
          hit_q   <= lk_hit;
          way_q   <= lk_way;
          prior_q <= mesi_q[cur_idx][lk_way];
          vtag_q  <= tag_q[cur_idx][lk_way];
        end
        S_UPDATE: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= 1'b0;
          resp_way_q   <= '0;
          resp_mesi_q  <= MESI_I;
          resp_evict_q <= 1'b0;
          resp_dirty_q <= 1'b0;
          resp_etag_q  <= '0;
          resp_flush_q <= 1'b0;
          case (cmd_q)
            CMD_RD_D, CMD_WR_D, CMD_RD_I: begin
              plru_q[cur_idx] <= plru_touch(plru_q[cur_idx], way_q);
              resp_way_q      <= way_q;
              if (hit_q) begin
                resp_hit_q  <= 1'b1;
                resp_mesi_q <= prior_q;
                hit_cntr_q  <= sat_inc(hit_cntr_q);
                if (cmd_q == CMD_WR_D) mesi_q[cur_idx][way_q] <= MESI_M;
              end else begin
                tag_q[cur_idx][way_q]  <= cur_tag;
                mesi_q[cur_idx][way_q] <= (cmd_q == CMD_WR_D) ? MESI_M :
                                          (snoop_shared ? MESI_S : MESI_E);
                resp_evict_q <= (prior_q != MESI_I);
                resp_dirty_q <= (prior_q == MESI_M);
                if (prior_q != MESI_I) resp_etag_q <= vtag_q;
                miss_cntr_q <= sat_inc(miss_cntr_q);
              end
              if (cmd_q == CMD_WR_D) write_cntr_q <= sat_inc(write_cntr_q);
              else                   read_cntr_q  <= sat_inc(read_cntr_q);
            end
            CMD_SN_IV, CMD_SN_RD, CMD_SN_WR, CMD_SN_RW: begin
              if (hit_q) begin
                resp_hit_q   <= 1'b1;
                resp_way_q   <= way_q;
                resp_mesi_q  <= prior_q;
                resp_flush_q <= (prior_q == MESI_M);
                mesi_q[cur_idx][way_q] <= (cmd_q == CMD_SN_RD) ? MESI_S : MESI_I;
              end
            end
            default: ;
          endcase
        end
        S_CLEAR: begin
          plru_q[clr_idx_q] <= '0;
          for (int w = 0; w < WAYS; w++) begin
            tag_q[clr_idx_q][w]  <= '0;
            mesi_q[clr_idx_q][w] <= MESI_I;
          end
          if (clr_idx_q == '0) begin
            hit_cntr_q   <= '0;
            miss_cntr_q  <= '0;
            read_cntr_q  <= '0;
            write_cntr_q <= '0;
          end
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == IDX_W'(SETS - 1)) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_mesi_q  <= MESI_I;
            resp_evict_q <= 1'b0;
            resp_dirty_q <= 1'b0;
            resp_etag_q  <= '0;
            resp_flush_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid       = resp_valid_q;
  assign resp_hit         = resp_hit_q;
  assign resp_way         = resp_way_q;
  assign resp_mesi        = resp_mesi_q;
  assign resp_evict       = resp_evict_q;
  assign resp_evict_dirty = resp_dirty_q;
  assign resp_evict_tag   = resp_etag_q;
  assign resp_flush       = resp_flush_q;
  assign hit_cntr         = hit_cntr_q;
  assign miss_cntr        = miss_cntr_q;
  assign read_cntr        = read_cntr_q;
  assign write_cntr       = write_cntr_q;

endmodule

// File: doc/cache_set_assoc_engine.md
# cache_set_assoc_engine

Parametrised successor of the single-configuration cache tracking model. Accepts one processor or snoop command at a time through a valid/ready handshake. Looks up a configurable N-way set-associative tag array and applies tree-PLRU replacement and MESI state transitions. Reports hit, victim and flush information per command and keeps saturating hit/miss/read/write statistics. Sits between the trace-driven command front end and the L2/bus reporting logic.

## Interface
Parameters:
- ADDR_W, 32, address width
- SETS, 64, number of sets; power of two, ≥2
- WAYS, 8, associativity; power of two, ≥2
- LINE_BYTES, 64, line size; power of two
- CNT_W, 16, statistics counter width

Derived widths:
- OFF_W = clog2(LINE_BYTES)
- IDX_W = clog2(SETS)
- TAG_W = ADDR_W−IDX_W−OFF_W
- WAY_W = clog2(WAYS)

Ports:
- clk  in  1  single clock, rising edge
- rstb  in  1  asynchronous, active-low reset
- req_valid  in  1  command present
- req_ready  out  1  engine idle, command accepted on req_valid&req_ready
- req_cmd  in  4  0 rd D, 1 wr D, 2 rd I, 3 snoop inval, 4 snoop rd, 5 snoop wr, 6 snoop RWITM, 8 clear, 9 print
- req_addr  in  ADDR_W  byte address
- snoop_shared  in  1  C line from other caches, sampled in UPDATE
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  tag match on a non-I line
- resp_way  out  WAY_W  hit way or filled way
- resp_mesi  out  2  state of the hit way before update (I=0,S=1,E=2,M=3)
- resp_evict  out  1  fill displaced a valid line
- resp_evict_dirty  out  1  displaced line was M (write-back)
- resp_evict_tag  out  TAG_W  tag of displaced line
- resp_flush  out  1  snoop hit a line in M
- hit_cntr, miss_cntr, read_cntr, write_cntr  out  CNT_W  statistics

## Operation
- Storage per set: WAYS×{tag, mesi} plus WAYS−1 PLRU bits, all in flops.
- States: IDLE, LOOKUP, UPDATE, CLEAR.
  - IDLE→LOOKUP on handshake for cmd 0–6 or 9/undefined.
  - IDLE→CLEAR for cmd 8.
  - LOOKUP→UPDATE always.
  - UPDATE→IDLE always.
  - CLEAR→IDLE after the last set.
- req_ready=1 only in IDLE. The command and address are registered at acceptance.
- LOOKUP: compares all ways in parallel and registers hit/way. Multiple matching ways cannot occur by construction.
- Victim selection on a miss: lowest-index I way if any exists, else the PLRU victim.
- PLRU: node 0 is the root; node i has children 2i+1 and 2i+2. Bit=0 means the victim lies in the left subtree. An access to way w sets each node on its path to point away from w.
- Cmd 0/2:
  - Hit: MESI unchanged, PLRU touched.
  - Miss: fill the victim with the new tag; state S if snoop_shared else E; PLRU touched.
  - read_cntr+1 in both cases.
- Cmd 1:
  - Hit: state→M, PLRU touched.
  - Miss: fill the victim in M, PLRU touched.
  - write_cntr+1 in both cases.
- Cmds 0–2: hit_cntr or miss_cntr +1. All counters saturate at all-ones.
- Snoops (cmd 3–6) on a hit:
  - Cmd 4: M/E→S.
  - Cmds 3/5/6: →I.
  - resp_flush=1 if the prior state was M.
- Snoops never fill, never touch PLRU and never count. A snoop miss has no effect.
- Cmd 9/undefined: no state change; response with all flags 0.
- Cmd 8: zeroes one set per CLEAR cycle (tags 0, mesi I, PLRU 0), index 0→SETS−1. All counters are zeroed on the first CLEAR cycle.

## Timing
- Reset (async, any state): state IDLE, arrays and PLRU zero, all counters 0, all resp_* 0, req_ready=1 once rstb is released.
- Command accepted at edge E:
  - Cycle after E: LOOKUP.
  - Next cycle: UPDATE.
  - Edge E+2 commits the arrays, PLRU and counters, and registers resp_*.
  - resp_valid=1 for exactly the cycle after E+2; req_ready=1 again from E+2.
  - Next command can be accepted at edge E+3. Back-to-back throughput is one command per 3 cycles.
- Clear accepted at E: CLEAR occupies SETS cycles. resp_valid pulses in the cycle after the final set is zeroed, with req_ready=1 in the same cycle.
- resp_* outputs other than resp_valid hold their values until the next response.
- snoop_shared is sampled only during UPDATE of cmd 0/2.
- Reset asserted mid-command: the in-flight command is dropped with no partial array write and no response.

## Test plan
- Reset. Read 0x0000_0040 (set 1, tag 0) → miss, way 0, E, miss_cntr=1. Repeat → resp_hit=1, way 0, resp_mesi=E, hit_cntr=1.
- 8-way set 1: read tags 0..7 → fill ways 0..7 with no evict. Read tag 8 → resp_evict=1, resp_evict_tag=0, resp_way=0 (PLRU).
- Write to the E line → hit, M. Snoop read (cmd 4) → resp_flush=1, S. Snoop inval (cmd 3) → I. Read → miss.
- Read miss with snoop_shared=1 → S. Write → hit, M. Evict this line via 8 new tags → resp_evict_dirty=1.
- Clear mid-stream → req_ready low for SETS cycles, then all counters 0 and every prior address misses.
- Assert rstb low during UPDATE of a write miss → all outputs 0, no resp_valid. After release the same write misses.
